// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake bundle between the pipeline datapath and its stall/flush sequencer.
// master = sequencer side (pipeline_ctrl), slave = datapath side.
interface pipeline_ctrl_if;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_branch_taken;
    logic       if_ready;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_bubble;

    modport master (
        input  ex_memread, ex_rd, id_rs1, id_rs2, id_uses_rs2,
               ex_branch_taken, if_ready, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_bubble
    );

    modport slave (
        output ex_memread, ex_rd, id_rs1, id_rs2, id_uses_rs2,
               ex_branch_taken, if_ready, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_bubble
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, IF/ID flush, ID/EX bubble,
// data-memory wait tracking with timeout, debug halt/step and a saturating stall counter.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TMR_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_ctrl_if.master  pif,
    input  logic             halt_req,
    input  logic             step,
    output logic             halt_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_stall;
    logic load_use;
    logic run_like;
    logic go;
    logic pc_en_raw, if_id_en_raw, id_ex_en_raw, ex_mem_en_raw, mem_wb_en_raw;
    logic if_id_flush_raw, id_bubble_raw;

    assign mem_stall = pif.mem_req & ~pif.mem_ready;
    assign load_use  = pif.ex_memread & (pif.ex_rd != 5'd0) &
                       ((pif.ex_rd == pif.id_rs1) |
                        (pif.id_uses_rs2 & (pif.ex_rd == pif.id_rs2)));
    assign run_like  = (state_q == ST_RUN) | (state_q == ST_MEM_WAIT);
    // A step while halt_req is already dropping is not honoured: that cycle only returns to RUN.
    assign go        = ~mem_stall & (run_like | ((state_q == ST_HALTED) & step & halt_req));

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        pc_en_raw       = 1'b0;
        if_id_en_raw    = 1'b0;
        id_ex_en_raw    = 1'b0;
        ex_mem_en_raw   = 1'b0;
        mem_wb_en_raw   = 1'b0;
        if_id_flush_raw = 1'b0;
        id_bubble_raw   = 1'b0;
        if (go) begin
            {pc_en_raw, if_id_en_raw, id_ex_en_raw, ex_mem_en_raw, mem_wb_en_raw} = 5'b11111;
            if (pif.ex_branch_taken) begin
                if_id_flush_raw = 1'b1;
                id_bubble_raw   = 1'b1;
            end else if (load_use) begin
                pc_en_raw     = 1'b0;
                if_id_en_raw  = 1'b0;
                id_bubble_raw = 1'b1;
            end else if (!pif.if_ready) begin
                pc_en_raw       = 1'b0;
                if_id_flush_raw = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    timer_d = TMR_W'(1);
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEM_WAIT: begin
                if (pif.mem_ready) begin
                    state_d = halt_req ? ST_HALTED : ST_RUN;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    state_d       = ST_ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step && mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    // Stalled cycles: RUN/MEM_WAIT cycles that freeze, or advance without moving the PC.
    always_comb begin
        stall_count_d = stall_count_q;
        if (run_like && (!go || !pc_en_raw) && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            timer_q       <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    // NOTE: reset also gates the combinational outputs, since state already reads RUN during reset.
    assign pif.pc_en       = pc_en_raw       & ~reset;
    assign pif.if_id_en    = if_id_en_raw    & ~reset;
    assign pif.id_ex_en    = id_ex_en_raw    & ~reset;
    assign pif.ex_mem_en   = ex_mem_en_raw   & ~reset;
    assign pif.mem_wb_en   = mem_wb_en_raw   & ~reset;
    assign pif.if_id_flush = if_id_flush_raw & ~reset;
    assign pif.id_bubble   = id_bubble_raw   & ~reset;
    assign halt_ack        = (state_q == ST_HALTED) & ~reset;
    assign mem_timeout     = mem_timeout_q;
    assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected output vectors go through a scoreboard
// queue and are compared against the DUT just before the next rising edge.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_bubble, halt_ack, mem_timeout}
    localparam logic [8:0] E_ZERO  = 9'b00000_00_0_0;
    localparam logic [8:0] E_ALL   = 9'b11111_00_0_0;
    localparam logic [8:0] E_LU    = 9'b00111_01_0_0;
    localparam logic [8:0] E_BR    = 9'b11111_11_0_0;
    localparam logic [8:0] E_MISS  = 9'b01111_10_0_0;
    localparam logic [8:0] E_HALT  = 9'b00000_00_1_0;
    localparam logic [8:0] E_HSTEP = 9'b11111_00_1_0;
    localparam logic [8:0] E_ERR   = 9'b00000_00_0_1;

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             halt_req;
    logic             step;
    logic             halt_ack;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(
        .TIMEOUT (4),
        .TMR_W   (8),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pif         (pif),
        .halt_req    (halt_req),
        .step        (step),
        .halt_ack    (halt_ack),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        pif.ex_memread      = 1'b0;
        pif.ex_rd           = 5'd0;
        pif.id_rs1          = 5'd0;
        pif.id_rs2          = 5'd0;
        pif.id_uses_rs2     = 1'b0;
        pif.ex_branch_taken = 1'b0;
        pif.if_ready        = 1'b1;
        pif.mem_req         = 1'b0;
        pif.mem_ready       = 1'b0;
        halt_req            = 1'b0;
        step                = 1'b0;
    endtask

    // Inputs are already applied (just after a falling edge); record the expectation,
    // compare before the rising edge, then move on to the next falling edge.
    task automatic cycle(input string tag, input logic [8:0] vec);
        exp_t item;
        exp_q.push_back('{tag, vec});
        #2;
        item = exp_q.pop_front();
        check(item.tag, {23'd0, pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en,
                         pif.mem_wb_en, pif.if_id_flush, pif.id_bubble, halt_ack, mem_timeout},
              {23'd0, item.vec});
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check(tag, 32'(stall_count), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b1;
        #1;
        check_cnt("rst_cnt", 0);
        cycle("rst_outputs", E_ZERO);
        reset = 1'b0;
        cycle("run_idle", E_ALL);
        check_cnt("idle_cnt", 0);

        // load x5 followed by a reader of x5: one bubble, then free flow
        pif.ex_memread = 1'b1; pif.ex_rd = 5'd5; pif.id_rs1 = 5'd5;
        cycle("load_use_rs1", E_LU);
        idle();
        cycle("after_bubble", E_ALL);
        check_cnt("lu_cnt", 1);

        // destination x0 never stalls
        pif.ex_memread = 1'b1; pif.ex_rd = 5'd0; pif.id_rs1 = 5'd0;
        cycle("load_x0", E_ALL);
        check_cnt("x0_cnt", 1);

        // rs2 hazard only counts when rs2 is actually read
        pif.ex_memread = 1'b1; pif.ex_rd = 5'd7; pif.id_rs1 = 5'd3; pif.id_rs2 = 5'd7;
        pif.id_uses_rs2 = 1'b1;
        cycle("load_use_rs2", E_LU);
        pif.id_uses_rs2 = 1'b0;
        cycle("rs2_unused", E_ALL);
        check_cnt("rs2_cnt", 2);

        // branch beats a simultaneous load-use
        pif.id_uses_rs2 = 1'b1; pif.ex_branch_taken = 1'b1;
        cycle("branch_over_lu", E_BR);
        check_cnt("br_cnt", 2);

        // fetch miss
        idle();
        pif.if_ready = 1'b0;
        cycle("fetch_miss", E_MISS);
        check_cnt("miss_cnt", 3);

        // three data-memory wait cycles, then completion
        idle();
        pif.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle("mem_wait", E_ZERO);
        pif.mem_ready = 1'b1;
        cycle("mem_done", E_ALL);
        check_cnt("mem_cnt", 6);

        // halt, two single steps, release
        idle();
        halt_req = 1'b1;
        cycle("halt_enter", E_ALL);
        cycle("halted", E_HALT);
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            cycle("step_go", E_HSTEP);
            step = 1'b0;
            cycle("step_hold", E_HALT);
        end
        halt_req = 1'b0;
        cycle("halt_leave", E_HALT);
        cycle("resumed", E_ALL);
        check_cnt("halt_cnt", 6);

        // step into a memory stall, finish it, return to HALTED
        halt_req = 1'b1;
        cycle("halt2_enter", E_ALL);
        cycle("halted2", E_HALT);
        step = 1'b1; pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
        cycle("step_stall", E_HALT);
        step = 1'b0;
        cycle("step_wait", E_ZERO);
        pif.mem_ready = 1'b1;
        cycle("step_mem_done", E_ALL);
        pif.mem_req = 1'b0; pif.mem_ready = 1'b0;
        cycle("back_halted", E_HALT);
        halt_req = 1'b0;
        cycle("halt2_leave", E_HALT);
        cycle("resumed2", E_ALL);
        check_cnt("step_cnt", 7);

        // memory never answers: RUN cycle plus 4 MEM_WAIT cycles, then ERROR
        pif.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) cycle("to_wait", E_ZERO);
        cycle("error", E_ERR);
        halt_req = 1'b1; step = 1'b1; pif.mem_ready = 1'b1;
        cycle("error_sticky", E_ERR);
        cycle("error_sticky2", E_ERR);
        check_cnt("err_cnt", 12);

        // reset is the only exit from ERROR
        idle();
        reset = 1'b1;
        #1;
        check_cnt("rst2_cnt", 0);
        cycle("rst2", E_ZERO);
        reset = 1'b0;
        cycle("rst2_run", E_ALL);

        // reset asserted mid-MEM_WAIT
        pif.mem_req = 1'b1;
        cycle("mw_a", E_ZERO);
        cycle("mw_b", E_ZERO);
        reset = 1'b1;
        #1;
        check_cnt("mw_rst_cnt", 0);
        cycle("mw_rst_out", E_ZERO);
        reset = 1'b0;
        idle();
        cycle("mw_rst_run", E_ALL);
        halt_req = 1'b1;
        cycle("mw_rst_halt", E_ALL);
        cycle("mw_rst_halted", E_HALT);
        halt_req = 1'b0;
        cycle("mw_rst_leave", E_HALT);
        cycle("mw_rst_resumed", E_ALL);
        check_cnt("mw_rst_cnt2", 0);

        // saturation at 2^CNT_W-1
        pif.ex_memread = 1'b1; pif.ex_rd = 5'd9; pif.id_rs1 = 5'd9;
        for (int i = 0; i < 20; i++) cycle("sat_lu", E_LU);
        check_cnt("sat_cnt", 15);
        idle();
        cycle("sat_idle", E_ALL);
        check_cnt("sat_hold", 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
